// File: rtl/exmem_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : exmem_stage_buf
// Brief    : EX/MEM pipeline register with valid/ready handshake, 2-entry skid
//            buffer and synchronous flush. Optional perf counters are enabled
//            by defining EXMEM_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module exmem_stage_buf #(
  parameter int XLEN  = 32,
  parameter int RDW   = 5,
  parameter int CNT_W = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rd2_in,
  input  logic [XLEN-1:0] add2_in,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [XLEN-1:0] mem_in,
  input  logic [RDW-1:0]  rd_in,
  input  logic            zero_in,
  input  logic            reg_write_in,
  input  logic            mem_to_reg_in,
  input  logic            mem_write_in,
  input  logic            mem_read_in,
  input  logic            branch_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd2_out,
  output logic [XLEN-1:0] add2_out,
  output logic [XLEN-1:0] alu_result_out,
  output logic [XLEN-1:0] mem_out,
  output logic [RDW-1:0]  rd_out,
  output logic            zero_out,
  output logic            reg_write_out,
  output logic            mem_to_reg_out,
  output logic            mem_write_out,
  output logic            mem_read_out,
  output logic            branch_out
`ifdef EXMEM_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] squash_cnt
`endif
);

  localparam int BW = 4 * XLEN + RDW + 6;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state, next_state;
  logic [BW-1:0]   main_q, skid_q, in_beat;
  logic            in_fire, out_fire;
  logic            load_main_in, load_main_skid, load_skid;
  logic            ctl_reg_write, ctl_mem_to_reg, ctl_mem_write, ctl_mem_read, ctl_branch;

  assign in_beat = {rd2_in, add2_in, alu_result_in, mem_in, rd_in, zero_in,
                    reg_write_in, mem_to_reg_in, mem_write_in, mem_read_in, branch_in};

  // in_ready comes straight from the state register, never from out_ready.
  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != FULL);
  assign in_fire   = in_valid & in_ready & ~flush;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      next_state = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            next_state   = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            next_state = FULL;
            load_skid  = 1'b1;
          end else if (out_fire) begin
            next_state = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            next_state     = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: next_state = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_beat;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_beat;
      end
    end
  end

  assign {rd2_out, add2_out, alu_result_out, mem_out, rd_out, zero_out,
          ctl_reg_write, ctl_mem_to_reg, ctl_mem_write, ctl_mem_read, ctl_branch} = main_q;

  // Control is squashed whenever the beat is not valid; data simply holds.
  assign reg_write_out  = ctl_reg_write  & out_valid;
  assign mem_to_reg_out = ctl_mem_to_reg & out_valid;
  assign mem_write_out  = ctl_mem_write  & out_valid;
  assign mem_read_out   = ctl_mem_read   & out_valid;
  assign branch_out     = ctl_branch     & out_valid;

`ifdef EXMEM_PERF_CNT_EN
  localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  logic [1:0]     squash_inc;
  logic [CNT_W:0] squash_sum;

  // A main beat leaving downstream in the flush cycle is consumed, not squashed.
  assign squash_inc = flush ? (2'((out_valid & ~out_ready)) + 2'((state == FULL)) + 2'(in_valid))
                            : 2'd0;
  assign squash_sum = {1'b0, squash_cnt} + (CNT_W + 1)'(squash_inc);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt  <= '0;
      squash_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      squash_cnt <= (squash_sum > CNT_MAX) ? {CNT_W{1'b1}} : squash_sum[CNT_W-1:0];
    end
  end
`else
  // Keeps CNT_W referenced when the counters are compiled out.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_exmem_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_exmem_stage_buf
// Brief    : Directed self-checking bench for exmem_stage_buf.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exmem_stage_buf;

  localparam int XLEN  = 32;
  localparam int RDW   = 5;
`ifdef EXMEM_PERF_CNT_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic            clock = 1'b0;
  logic            reset_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [XLEN-1:0] rd2_in, add2_in, alu_result_in, mem_in;
  logic [XLEN-1:0] rd2_out, add2_out, alu_result_out, mem_out;
  logic [RDW-1:0]  rd_in, rd_out;
  logic zero_in, reg_write_in, mem_to_reg_in, mem_write_in, mem_read_in, branch_in;
  logic zero_out, reg_write_out, mem_to_reg_out, mem_write_out, mem_read_out, branch_out;
`ifdef EXMEM_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, squash_cnt;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clock = ~clock;

  exmem_stage_buf #(.XLEN(XLEN), .RDW(RDW), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .rd2_in(rd2_in), .add2_in(add2_in), .alu_result_in(alu_result_in), .mem_in(mem_in),
    .rd_in(rd_in), .zero_in(zero_in), .reg_write_in(reg_write_in),
    .mem_to_reg_in(mem_to_reg_in), .mem_write_in(mem_write_in),
    .mem_read_in(mem_read_in), .branch_in(branch_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .rd2_out(rd2_out), .add2_out(add2_out), .alu_result_out(alu_result_out), .mem_out(mem_out),
    .rd_out(rd_out), .zero_out(zero_out), .reg_write_out(reg_write_out),
    .mem_to_reg_out(mem_to_reg_out), .mem_write_out(mem_write_out),
    .mem_read_out(mem_read_out), .branch_out(branch_out)
`ifdef EXMEM_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .squash_cnt(squash_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  // Advance one edge; inputs and checks then sit 1 time unit after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 0; in_valid = 0; out_ready = 0;
    rd2_in = '0; add2_in = '0; alu_result_in = '0; mem_in = '0; rd_in = '0;
    zero_in = 0; reg_write_in = 0; mem_to_reg_in = 0;
    mem_write_in = 0; mem_read_in = 0; branch_in = 0;
  endtask

  initial begin
    reset_n = 0;
    clear_inputs();
    step(); step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_alu", 64'(alu_result_out), 64'd0);
    reset_n = 1;
    step();

    // Streaming with out_ready held high
    out_ready = 1; in_valid = 1; reg_write_in = 1; rd_in = 5'd3;
    alu_result_in = 32'h10;
    step();
    check("stream_v0", 64'(out_valid), 64'd1);
    check("stream_a0", 64'(alu_result_out), 64'h10);
    check("stream_rw0", 64'(reg_write_out), 64'd1);
    alu_result_in = 32'h20;
    step();
    check("stream_v1", 64'(out_valid), 64'd1);
    check("stream_a1", 64'(alu_result_out), 64'h20);
    alu_result_in = 32'h30;
    step();
    check("stream_a2", 64'(alu_result_out), 64'h30);
    check("stream_rdy", 64'(in_ready), 64'd1);
    // Full-field pass-through beat
    rd2_in = 32'hDEADBEEF; add2_in = 32'h12345678; alu_result_in = 32'h8000_0001;
    mem_in = 32'hCAFEF00D; rd_in = 5'h1F; zero_in = 1; branch_in = 1;
    mem_to_reg_in = 1; reg_write_in = 0;
    step();
    check("pt_rd2", 64'(rd2_out), 64'hDEADBEEF);
    check("pt_add2", 64'(add2_out), 64'h12345678);
    check("pt_alu", 64'(alu_result_out), 64'h80000001);
    check("pt_mem", 64'(mem_out), 64'hCAFEF00D);
    check("pt_rd", 64'(rd_out), 64'h1F);
    check("pt_flags", {58'd0, zero_out, reg_write_out, mem_to_reg_out,
                       mem_write_out, mem_read_out, branch_out}, 64'b101001);
    clear_inputs(); out_ready = 1;
    step();
    check("drain_valid", 64'(out_valid), 64'd0);
    check("drain_gate", {59'd0, reg_write_out, mem_to_reg_out, mem_write_out,
                         mem_read_out, branch_out}, 64'd0);
    check("drain_hold", 64'(alu_result_out), 64'h80000001);

    // Backpressure into the skid entry
    out_ready = 0; in_valid = 1; alu_result_in = 32'hA;
    step();
    check("bp_a_out", 64'(alu_result_out), 64'hA);
    check("bp_rdy1", 64'(in_ready), 64'd1);
    alu_result_in = 32'hB;
    step();
    check("bp_rdy_full", 64'(in_ready), 64'd0);
    check("bp_hold_a", 64'(alu_result_out), 64'hA);
    in_valid = 0; alu_result_in = 32'hC;
    step();
    check("bp_stable", 64'(alu_result_out), 64'hA);
    check("bp_valid", 64'(out_valid), 64'd1);
    out_ready = 1;
    step();
    check("bp_b_out", 64'(alu_result_out), 64'hB);
    check("bp_rdy2", 64'(in_ready), 64'd1);
    step();
    check("bp_empty", 64'(out_valid), 64'd0);

    // Flush while FULL with an incoming beat
    out_ready = 0; in_valid = 1; alu_result_in = 32'h1;
    step();
    alu_result_in = 32'h2;
    step();
    check("fl_full", 64'(in_ready), 64'd0);
`ifdef EXMEM_PERF_CNT_EN
    check("sq_before", 64'(squash_cnt), 64'd0);
`endif
    alu_result_in = 32'h3; reg_write_in = 1; mem_write_in = 1; flush = 1;
    step();
    flush = 0; in_valid = 0;
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_rw", 64'(reg_write_out), 64'd0);
    check("fl_mw", 64'(mem_write_out), 64'd0);
    check("fl_rdy", 64'(in_ready), 64'd1);
`ifdef EXMEM_PERF_CNT_EN
    check("sq_full", 64'(squash_cnt), 64'd3);
`endif
    step();
    check("fl_no_ghost", 64'(out_valid), 64'd0);

    // Flush coincident with out_fire in ONE
    clear_inputs();
    out_ready = 1; in_valid = 1; alu_result_in = 32'h44; mem_read_in = 1;
    step();
    check("fo_one", 64'(alu_result_out), 64'h44);
    alu_result_in = 32'h55; flush = 1;
    step();
    flush = 0; in_valid = 0;
    check("fo_valid", 64'(out_valid), 64'd0);
    check("fo_hold", 64'(alu_result_out), 64'h44);
    check("fo_mr", 64'(mem_read_out), 64'd0);
`ifdef EXMEM_PERF_CNT_EN
    check("sq_one", 64'(squash_cnt), 64'd4);
`endif
    step();
    check("fo_no_dup", 64'(out_valid), 64'd0);

    // Asynchronous reset from FULL, between edges
    clear_inputs();
    in_valid = 1; reg_write_in = 1; rd_in = 5'd7; alu_result_in = 32'h77;
    step(); step();
    in_valid = 0;
    check("ar_full", 64'(in_ready), 64'd0);
    #2 reset_n = 0;
    #1;
    check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_rdy", 64'(in_ready), 64'd1);
    check("ar_rw", 64'(reg_write_out), 64'd0);
    check("ar_alu", 64'(alu_result_out), 64'd0);
    check("ar_rd", 64'(rd_out), 64'd0);
    #2 reset_n = 1;
    step();
    check("ar_after", 64'(out_valid), 64'd0);
`ifdef EXMEM_PERF_CNT_EN
    check("cnt_rst", {32'd0, 28'(stall_cnt), 4'(squash_cnt)}, 64'd0);
    in_valid = 1; alu_result_in = 32'h99;
    step();
    in_valid = 0;
    for (int i = 0; i < 20; i++) step();
    check("stall_sat", 64'(stall_cnt), 64'd15);
    check("sat_hold", 64'(alu_result_out), 64'h99);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
